// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, widths and the decoded-instruction record
// for the decode/operand-fetch stage and its register file.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI = 4'h1;
  localparam logic [3:0] OP_ORI = 4'h2;
  localparam logic [3:0] OP_XORI = 4'h3;
  localparam logic [3:0] OP_MEM = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI = 4'h9;
  localparam logic [3:0] OP_CMPI = 4'hB;
  localparam logic [3:0] OP_MOVI = 4'hD;
  localparam logic [3:0] OP_LUI = 4'hF;
  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STORE = 4'h4;
  localparam logic [3:0] EXT_LSH = 4'h4;
  localparam logic [3:0] EXT_CMP = 4'hB;
  localparam logic [3:0] EXT_MOV = 4'hD;
  typedef enum logic {ST_RUN, ST_WAIT} state_t;
  typedef struct packed {
    logic [7:0] opcode;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] dest;
    logic use_a;
    logic use_b;
    logic imm_sel;
    logic dest_we;
    logic [DATA_W-1:0] imm;
  } dec_t;
  typedef struct packed {
    logic [AW-1:0] dest;
    logic we;
    logic fwd;
  } hist_t;
  // ALU function codes shared by the register form (ext) and immediate form (op)
  function automatic logic alu_fn(input logic [3:0] f);
    return f inside {OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI, OP_SUBI, OP_CMPI, OP_MOVI};
  endfunction
  function automatic dec_t decode(input logic [15:0] i);
    dec_t d;
    logic [3:0] op;
    logic [3:0] ext;
    op = i[15:12];
    ext = i[7:4];
    d = '0;
    d.ra = i[11:8];
    d.rb = i[3:0];
    d.dest = i[11:8];
    d.use_a = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.opcode = {OP_RTYPE, ext};
        d.use_a = ext != EXT_MOV;
        d.use_b = 1'b1;
        d.dest_we = alu_fn(ext) && ext != EXT_CMP;
      end
      OP_MEM: begin
        d.opcode = {OP_MEM, ext};
        d.ra = i[3:0];
        d.rb = i[11:8];
        d.use_b = ext == EXT_STORE;
        d.dest_we = ext == EXT_LOAD;
      end
      OP_SHIFT: begin
        d.opcode = {OP_SHIFT, ext};
        d.imm_sel = ext[3:1] == 3'b000;
        d.imm = {12'b0, i[3:0]};
        d.use_b = ext[3:1] != 3'b000;
        d.dest_we = 1'b1;
      end
      OP_LUI: begin
        d.opcode = {OP_LUI, 4'h0};
        d.imm = {8'b0, i[7:0]};
        d.imm_sel = 1'b1;
        d.use_a = 1'b0;
        d.dest_we = 1'b1;
      end
      default: begin
        if (alu_fn(op)) begin
          d.opcode = {4'h0, op};
          d.imm_sel = 1'b1;
          d.imm = op inside {OP_ANDI, OP_ORI, OP_XORI} ? {8'b0, i[7:0]} : {{8{i[7]}}, i[7:0]};
          d.use_a = op != OP_MOVI;
          d.dest_we = op != OP_CMPI;
        end else begin
          d.use_a = 1'b0;
        end
      end
    endcase
    return d;
  endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: fetch, writeback and ALU-issue signals of the operand-fetch stage.
interface operand_fetch_stage_if;
  import cpu_pkg::*;
  logic instr_valid;
  logic [15:0] instr;
  logic instr_ready;
  logic stall;
  logic wb_en;
  logic [AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] alu_result;
  logic [7:0] opcode;
  logic [DATA_W-1:0] rdataA;
  logic [DATA_W-1:0] rdataB;
  logic [AW-1:0] dest;
  logic dest_we;
  logic issue_valid;
  modport slave (
    input instr_valid, instr, stall, wb_en, wb_addr, wb_data, alu_result,
    output instr_ready, opcode, rdataA, rdataB, dest, dest_we, issue_valid
  );
  modport master (
    output instr_valid, instr, stall, wb_en, wb_addr, wb_data, alu_result,
    input instr_ready, opcode, rdataA, rdataB, dest, dest_we, issue_valid
  );
endinterface

// File: rtl/reg_file_16x16.sv
// reg_file_16x16: 2-read/1-write register file; a read of the register being
// written this cycle returns the write data.
module reg_file_16x16
  import cpu_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  always_ff @(posedge clock) begin
    if (!reset) regs_q <= '{default: '0};
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  end
  assign rdata_a_o = we_i && waddr_i == raddr_a_i ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = we_i && waddr_i == raddr_b_i ? wdata_i : regs_q[raddr_b_i];
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode, register read, RAW scoreboard and bubble insertion ahead of the ALU.
// Define OPFETCH_FWD_EN to forward alu_result for a source written two issue slots earlier.
module operand_fetch_stage
  import cpu_pkg::*;
(
  input logic clock,
  input logic reset,
  operand_fetch_stage_if.slave bus
);
  state_t state_q;
  dec_t held_q;
  dec_t cur;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic cur_valid;
  logic busy_a;
  logic busy_b;
  logic fwd_a;
  logic fwd_b;
  logic hazard;
  logic go;
  logic [7:0] opcode_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [AW-1:0] dest_q;
  logic dest_we_q;
  logic issue_valid_q;
  reg_file_16x16 u_rf (
    .clock(clock),
    .reset(reset),
    .we_i(bus.wb_en),
    .waddr_i(bus.wb_addr),
    .wdata_i(bus.wb_data),
    .raddr_a_i(cur.ra),
    .raddr_b_i(cur.rb),
    .rdata_a_o(rd_a),
    .rdata_b_o(rd_b)
  );
  // While waiting, the held copy is the instruction fetch keeps presenting until ready
  assign cur = state_q == ST_WAIT ? held_q : decode(bus.instr);
  assign cur_valid = state_q == ST_WAIT || bus.instr_valid;
  assign busy_a = cur.use_a && busy_q[cur.ra] && !(bus.wb_en && bus.wb_addr == cur.ra);
  assign busy_b = cur.use_b && busy_q[cur.rb] && !(bus.wb_en && bus.wb_addr == cur.rb);
`ifdef OPFETCH_FWD_EN
  hist_t h1_q;
  hist_t h2_q;
  assign fwd_a = busy_a && h2_q.fwd && h2_q.dest == cur.ra && !(h1_q.we && h1_q.dest == cur.ra);
  assign fwd_b = busy_b && h2_q.fwd && h2_q.dest == cur.rb && !(h1_q.we && h1_q.dest == cur.rb);
  always_ff @(posedge clock) begin
    if (!reset) begin
      h1_q <= '0;
      h2_q <= '0;
    end else if (go) begin
      h1_q <= '{dest: cur.dest, we: cur.dest_we, fwd: cur.dest_we && cur.opcode != {OP_MEM, EXT_LOAD}};
      h2_q <= h1_q;
    end
  end
`else
  logic unused_alu;
  assign unused_alu = ^bus.alu_result;
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif
  assign hazard = (busy_a && !fwd_a) || (busy_b && !fwd_b);
  assign go = cur_valid && !bus.stall && !hazard;
  assign op_a = fwd_a ? bus.alu_result : rd_a;
  assign op_b = cur.imm_sel ? cur.imm : fwd_b ? bus.alu_result : rd_b;
  // Set after clear so an issue to the register being written back keeps it busy
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;
    if (go && cur.dest_we) busy_d[cur.dest] = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      held_q <= '0;
      busy_q <= '0;
      opcode_q <= '0;
      a_q <= '0;
      b_q <= '0;
      dest_q <= '0;
      dest_we_q <= 1'b0;
      issue_valid_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (!bus.stall) begin
        state_q <= cur_valid && hazard ? ST_WAIT : ST_RUN;
        held_q <= cur;
        issue_valid_q <= go;
        opcode_q <= go ? cur.opcode : '0;
        a_q <= go ? op_a : '0;
        b_q <= go ? op_b : '0;
        dest_q <= go ? cur.dest : '0;
        dest_we_q <= go && cur.dest_we;
      end
    end
  end
  assign bus.instr_ready = !bus.stall && !hazard;
  assign bus.opcode = opcode_q;
  assign bus.rdataA = a_q;
  assign bus.rdataB = b_q;
  assign bus.dest = dest_q;
  assign bus.dest_we = dest_we_q;
  assign bus.issue_valid = issue_valid_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed vectors; expected issues are queued by the
// stimulus and checked by a monitor whenever a new instruction is issued.
module tb_operand_fetch_stage;
  typedef struct packed {
    logic [7:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0] d;
    logic we;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stall_at_edge = 1'b0;
  exp_t expq[$];
  int passed = 0;
  int total = 0;
  always #5 clock = ~clock;
  operand_fetch_stage_if bus();
  operand_fetch_stage dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [15:0] ins, input exp_t e);
    int n;
    n = 0;
    expq.push_back(e);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    #1;
    while (!bus.instr_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (n == 20) chk("accept timeout", 32'd0, 32'd1);
    tick();
    bus.instr_valid = 1'b0;
  endtask
  task automatic wb(input logic [3:0] addr, input logic [15:0] data);
    bus.wb_en = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    tick();
    bus.wb_en = 1'b0;
  endtask
  always @(posedge clock) stall_at_edge <= bus.stall;
  always @(negedge clock) begin
    exp_t e;
    if (reset && bus.issue_valid && !stall_at_edge) begin
      if (expq.size() == 0) chk("unexpected issue", {24'b0, bus.opcode}, 32'hFFFF_FFFF);
      else begin
        e = expq.pop_front();
        chk("opcode", {24'b0, bus.opcode}, {24'b0, e.op});
        chk("rdataA", {16'b0, bus.rdataA}, {16'b0, e.a});
        chk("rdataB", {16'b0, bus.rdataB}, {16'b0, e.b});
        chk("dest", {28'b0, bus.dest}, {28'b0, e.d});
        chk("dest_we", {31'b0, bus.dest_we}, {31'b0, e.we});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.stall = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.alu_result = '0;
    repeat (2) tick();
    chk("reset opcode", {24'b0, bus.opcode}, 32'h0);
    chk("reset rdataA", {16'b0, bus.rdataA}, 32'h0);
    chk("reset rdataB", {16'b0, bus.rdataB}, 32'h0);
    chk("reset dest", {28'b0, bus.dest}, 32'h0);
    chk("reset dest_we", {31'b0, bus.dest_we}, 32'h0);
    chk("reset issue_valid", {31'b0, bus.issue_valid}, 32'h0);
    reset = 1'b1;
    tick();
    send(16'h5105, '{8'h05, 16'h0000, 16'h0005, 4'h1, 1'b1});
    wb(4'h1, 16'h0005);
    wb(4'h2, 16'h1234);
    send(16'h0352, '{8'h05, 16'h0000, 16'h1234, 4'h3, 1'b1});
    // RAW on R1: bubbles until its writeback arrives
    send(16'h5105, '{8'h05, 16'h0005, 16'h0005, 4'h1, 1'b1});
    expq.push_back('{8'h05, 16'h0000, 16'h0055, 4'h4, 1'b1});
    bus.instr = 16'h0451;
    bus.instr_valid = 1'b1;
    #1;
    chk("hazard ready", {31'b0, bus.instr_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble issue_valid", {31'b0, bus.issue_valid}, 32'h0);
      chk("bubble ready", {31'b0, bus.instr_ready}, 32'h0);
    end
    bus.wb_en = 1'b1;
    bus.wb_addr = 4'h1;
    bus.wb_data = 16'h0055;
    #1;
    chk("wb release ready", {31'b0, bus.instr_ready}, 32'h1);
    tick();
    bus.wb_en = 1'b0;
    bus.instr_valid = 1'b0;
    send(16'hF5AB, '{8'hF0, 16'h0000, 16'h00AB, 4'h5, 1'b1});
    send(16'h16FF, '{8'h01, 16'h0000, 16'h00FF, 4'h6, 1'b1});
    wb(4'h6, 16'h0010);
    send(16'h56FF, '{8'h05, 16'h0010, 16'hFFFF, 4'h6, 1'b1});
    send(16'h07B2, '{8'h0B, 16'h0000, 16'h1234, 4'h7, 1'b0});
    send(16'h4842, '{8'h44, 16'h1234, 16'h0000, 4'h8, 1'b0});
    send(16'h4902, '{8'h40, 16'h1234, 16'h0000, 4'h9, 1'b1});
    send(16'h8A03, '{8'h80, 16'h0000, 16'h0003, 4'hA, 1'b1});
    send(16'h8C42, '{8'h84, 16'h0000, 16'h1234, 4'hC, 1'b1});
    send(16'h7123, '{8'h00, 16'h0055, 16'h0000, 4'h1, 1'b0});
    send(16'hB1FF, '{8'h0B, 16'h0055, 16'hFFFF, 4'h1, 1'b0});
    // Stall holds the issued ADDI R13 while a writeback to R14 still lands
    send(16'h5D01, '{8'h05, 16'h0000, 16'h0001, 4'hD, 1'b1});
    bus.stall = 1'b1;
    bus.wb_en = 1'b1;
    bus.wb_addr = 4'hE;
    bus.wb_data = 16'hBEEF;
    bus.instr = 16'h0F5E;
    bus.instr_valid = 1'b1;
    #1;
    chk("stall ready", {31'b0, bus.instr_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_en = 1'b0;
      chk("stall issue_valid", {31'b0, bus.issue_valid}, 32'h1);
      chk("stall opcode", {24'b0, bus.opcode}, 32'h05);
      chk("stall rdataB", {16'b0, bus.rdataB}, 32'h0001);
      chk("stall dest", {28'b0, bus.dest}, 32'hD);
      chk("stall ready", {31'b0, bus.instr_ready}, 32'h0);
    end
    bus.stall = 1'b0;
    send(16'h0F5E, '{8'h05, 16'h0000, 16'hBEEF, 4'hF, 1'b1});
    // Reset while waiting on busy R13 drops the held instruction and clears the scoreboard
    bus.instr = 16'h005D;
    bus.instr_valid = 1'b1;
    #1;
    chk("wait ready", {31'b0, bus.instr_ready}, 32'h0);
    tick();
    chk("wait issue_valid", {31'b0, bus.issue_valid}, 32'h0);
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    chk("post-reset issue_valid", {31'b0, bus.issue_valid}, 32'h0);
    tick();
    chk("dropped issue_valid", {31'b0, bus.issue_valid}, 32'h0);
    bus.instr = 16'h005D;
    bus.instr_valid = 1'b1;
    expq.push_back('{8'h05, 16'h0000, 16'h0000, 4'h0, 1'b1});
    #1;
    chk("scoreboard clear ready", {31'b0, bus.instr_ready}, 32'h1);
    tick();
    bus.instr_valid = 1'b0;
    repeat (3) tick();
    chk("queue drained", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage sitting directly upstream of the ALU.
- Accepts 16-bit instructions from fetch and decodes them into the ALU's 8-bit opcode plus two 16-bit operands.
- Holds the 16x16 register file, which is written back from downstream.
- Tracks in-flight destination registers with a scoreboard and inserts bubbles on read-after-write (RAW) hazards.

Parameters:
- NUM_REGS, 16, register count; address width is log2(NUM_REGS).
- DATA_W, 16, register and operand width.

Ports:
- clock  in  1  stage clock
- reset  in  1  synchronous, active-low
- instr_valid  in  1  fetch presents instruction
- instr  in  16  instruction word
- instr_ready  out  1  stage accepts instr this cycle
- stall  in  1  downstream hold; freezes all issue outputs
- wb_en  in  1  register write enable
- wb_addr  in  4  register write address
- wb_data  in  16  register write data
- alu_result  in  16  ALU result bus, used for forwarding
- opcode  out  8  ALU opcode {op, ext}
- rdataA  out  16  ALU operand A
- rdataB  out  16  ALU operand B
- dest  out  4  destination register of issued instruction
- dest_we  out  1  issued instruction writes dest
- issue_valid  out  1  outputs hold a real instruction this cycle

Behaviour:
- Clock and reset: reset reset, synchronous, active-low; clock clock.
- Reset values: all outputs 0 (opcode 8'h00, which the ALU treats as zero result); all registers 0; scoreboard clear; FSM in RUN.
- Reset mid-operation discards any held or bubbled instruction.
- Instruction fields: op=instr[15:12], Rd=instr[11:8], ext=instr[7:4], Rs=instr[3:0], imm=instr[7:0].
- Decode, op 0000 (register form):
  - opcode={0000,ext}; A=R[Rd]; B=R[Rs].
  - dest_we=1, except CMP (ext 1011) and unknown ext, which give dest_we=0.
- Decode, op in {0001,0010,0011,0101,0110,1001,1011,1101} (immediate form):
  - opcode={0000,op}; A=R[Rd].
  - B = zero-extended imm for AND/OR/XOR (0001..0011); sign-extended imm otherwise.
  - dest_we=1 except CMPI.
- Decode, op 0100 (memory):
  - opcode={0100,ext}; A=R[Rs] (address); B=R[Rd].
  - LOAD (ext 0000): dest_we=1. STORE (ext 0100): dest_we=0.
- Decode, op 1000 (shift):
  - ext 0100 (LSH): B=R[Rs].
  - ext 000x: B={12'b0, instr[3:0]}.
  - opcode={1000,ext}; A=R[Rd]; dest_we=1.
- Decode, op 1111 (LUI): opcode 8'hF0; B={8'b0, imm}; A=R[Rd]; dest_we=1.
- Illegal op: issued as NOP with opcode 8'h00, dest_we=0, issue_valid=1.
- Scoreboard: one busy bit per register.
  - Set when an instruction with dest_we=1 issues.
  - Cleared by wb_en at wb_addr.
  - If set and clear hit the same register in the same cycle, set wins.
- Register read: a read of a register being written this cycle (wb_en && wb_addr match) returns wb_data and counts as not busy.
- Hazard: an instruction whose sources (or Rd, for read-modify ops) are busy is not accepted. instr_ready=0 and the FSM enters WAIT.
- FSM states:
  - RUN: accepts when instr_valid && !stall && no hazard; outputs register at next edge with issue_valid=1. With no instr_valid, issue_valid=0.
  - WAIT: issue_valid=0 (bubble); the instruction is held internally. Returns to RUN and issues once all its sources are non-busy.
- stall=1: opcode, rdata, dest, dest_we and issue_valid hold their values; instr_ready=0; no scoreboard set; writeback still updates regs and scoreboard.
- Latency: 1 cycle from acceptance to outputs when there is no hazard.
- Wrap-around: none; register address is 4 bits exact.

Optional Feature:
- Macro: OPFETCH_FWD_EN.
- Defined: if a busy source was set by the non-LOAD instruction issued exactly two issue slots earlier, the operand is taken from alu_result and no bubble is inserted.
- Undefined: no forwarding; that case bubbles until writeback clears the bit.

Decomposition:
- Shared package cpu_pkg holds:
  - op/ext opcode constants (OP_RTYPE, OP_MEM, OP_SHIFT, OP_LUI, EXT_LOAD, EXT_STORE, EXT_CMP, ...).
  - DATA_W.
  - The decoded-instruction struct typedef.
- Sub-module reg_file_16x16: 2 read ports, 1 write port, write-bypass; reset-clears contents.

Test Plan:
- Reset then ADDI R1,#5 (instr 16'h5105) -> next cycle opcode 8'h05, rdataA 0, rdataB 16'h0005, dest 1, dest_we 1, issue_valid 1.
- wb R2=16'h1234 then ADD R3,R2 (16'h0352) -> rdataA 0, rdataB 16'h1234, opcode 8'h05.
- ADDI R1,#5 immediately followed by ADD R4,R1 (16'h0451) -> one or more bubble cycles (issue_valid=0, instr_ready=0) until wb_addr=1 arrives; then rdataB equals wb_data.
- LUI R5,#8'hAB (16'hF5AB) -> opcode 8'hF0, rdataB 16'h00AB; ANDI R6,#8'hFF -> rdataB 16'h00FF; ADDI R6,#8'hFF -> rdataB 16'hFFFF.
- stall=1 held 3 cycles mid-stream -> outputs unchanged, instr_ready=0; a writeback during the stall updates the regfile.
- Reset asserted while in WAIT -> next cycle issue_valid=0, scoreboard clear, held instruction dropped.
